// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execute-stage arithmetic for the single-cycle MIPS-lite datapath:
//   - ALU-control decode (aluop/funct -> gout)
//   - 32-bit ALU with combinational zero output
//   - PC+4 and branch-target adders
//   - registered N/V/Z status flags for branch-on-overflow/negative
// Build option: define ALU_STATUS_EN to include the status flag registers
// and overflow logic. When it is undefined the flags read as 0 and
// status_we has no effect.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  input  logic        status_we,
  output logic [3:0]  gout,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  output logic        status_n,
  output logic        status_v,
  output logic        status_z
);

  localparam logic [3:0] G_AND = 4'b0000;
  localparam logic [3:0] G_OR  = 4'b0001;
  localparam logic [3:0] G_ADD = 4'b0010;
  localparam logic [3:0] G_XOR = 4'b0011;
  localparam logic [3:0] G_SUB = 4'b0110;
  localparam logic [3:0] G_SLT = 4'b0111;
  localparam logic [3:0] G_NOR = 4'b1100;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  logic [31:0] sum;
  logic [31:0] diff;
  logic        ovf_sub;
  logic        slt_bit;
  logic [31:0] imm_shifted;

  // R-type funct decode; unknown functs fall back to ADD
  function automatic logic [3:0] decode_funct(input logic [5:0] f);
    logic [3:0] g;
    g = G_ADD;
    case (f)
      F_ADD:   g = G_ADD;
      F_SUB:   g = G_SUB;
      F_AND:   g = G_AND;
      F_OR:    g = G_OR;
      F_XOR:   g = G_XOR;
      F_NOR:   g = G_NOR;
      F_SLT:   g = G_SLT;
      default: g = G_ADD;
    endcase
    return g;
  endfunction

  // ALU control: map the operation class from main control onto gout
  always_comb begin
    gout = G_ADD;
    case (aluop)
      3'b000:  gout = G_ADD;
      3'b001:  gout = G_SUB;
      3'b010:  gout = decode_funct(funct);
      3'b011:  gout = G_OR;
      3'b100:  gout = G_NOR;
      3'b101:  gout = G_AND;
      3'b110:  gout = G_SLT;
      3'b111:  gout = G_XOR;
      default: gout = G_ADD;
    endcase
  end

  assign sum  = a + b;
  assign diff = a - b;

  // Signed overflow of a - b; SLT uses it so the compare stays correct
  // when the difference wraps (e.g. 0x80000000 - 1).
  assign ovf_sub = (a[31] != b[31]) && (diff[31] != a[31]);
  assign slt_bit = diff[31] ^ ovf_sub;

  // ALU datapath; unlisted gout codes produce 0
  always_comb begin
    result = 32'd0;
    case (gout)
      G_ADD:   result = sum;
      G_SUB:   result = diff;
      G_AND:   result = a & b;
      G_OR:    result = a | b;
      G_XOR:   result = a ^ b;
      G_NOR:   result = ~(a | b);
      G_SLT:   result = {31'd0, slt_bit};
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

  // PC adders, both wrap modulo 2^32
  assign imm_shifted   = {{14{imm16[15]}}, imm16, 2'b00};
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + imm_shifted;

`ifdef ALU_STATUS_EN
  logic ovf_add;
  logic v_next;

  assign ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);

  // Overflow is only meaningful for the arithmetic operations
  always_comb begin
    v_next = 1'b0;
    case (gout)
      G_ADD:   v_next = ovf_add;
      G_SUB:   v_next = ovf_sub;
      default: v_next = 1'b0;
    endcase
  end

  // Status flags: capture on status_we, reset clears immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_n <= 1'b0;
      status_v <= 1'b0;
      status_z <= 1'b0;
    end else if (status_we) begin
      status_n <= result[31];
      status_v <= v_next;
      status_z <= zero;
    end
  end
`else
  logic unused_status;

  assign status_n = 1'b0;
  assign status_v = 1'b0;
  assign status_z = 1'b0;

  // Flag inputs have no function without the status registers
  assign unused_status = &{1'b0, clk, rst_n, status_we};
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit. A behavioural model (integer
// arithmetic and lookup tables) predicts every output; flags are modelled
// only when ALU_STATUS_EN is defined, otherwise they must stay 0.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [15:0] imm16;
  logic        status_we;
  logic [3:0]  gout;
  logic [31:0] result;
  logic        zero;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        status_n;
  logic        status_v;
  logic        status_z;

  int checks = 0;
  int passes = 0;

  // model flags
  logic exp_n = 1'b0;
  logic exp_v = 1'b0;
  logic exp_z = 1'b0;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .aluop(aluop), .funct(funct), .a(a), .b(b),
    .pc(pc), .imm16(imm16), .status_we(status_we), .gout(gout),
    .result(result), .zero(zero), .pc_plus4(pc_plus4),
    .branch_target(branch_target), .status_n(status_n),
    .status_v(status_v), .status_z(status_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_gout(input logic [2:0] op, input logic [5:0] f);
    logic [3:0] g;
    g = 4'b0010;
    case (op)
      3'd0: g = 4'b0010;
      3'd1: g = 4'b0110;
      3'd3: g = 4'b0001;
      3'd4: g = 4'b1100;
      3'd5: g = 4'b0000;
      3'd6: g = 4'b0111;
      3'd7: g = 4'b0011;
      default: begin
        if      (f == 6'd32) g = 4'b0010;
        else if (f == 6'd34) g = 4'b0110;
        else if (f == 6'd36) g = 4'b0000;
        else if (f == 6'd37) g = 4'b0001;
        else if (f == 6'd38) g = 4'b0011;
        else if (f == 6'd39) g = 4'b1100;
        else if (f == 6'd42) g = 4'b0111;
        else                 g = 4'b0010;
      end
    endcase
    return g;
  endfunction

  function automatic logic [31:0] m_result(input logic [3:0] g, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (g)
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0011: return x ^ y;
      4'b1100: return ~(x | y);
      4'b0111: return (sx < sy) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // overflow: exact signed result falls outside the 32-bit range
  function automatic logic m_ovf(input logic [3:0] g, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (g == 4'b0010)      r = sx + sy;
    else if (g == 4'b0110) r = sx - sy;
    else                   return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic set_ops(input logic [2:0] op, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y);
    aluop = op;
    funct = f;
    a     = x;
    b     = y;
  endtask

  // called at a rising edge: update model flags from the current inputs
  task automatic model_edge();
    logic [3:0]  g;
    logic [31:0] r;
`ifdef ALU_STATUS_EN
    if (rst_n && status_we) begin
      g = m_gout(aluop, funct);
      r = m_result(g, a, b);
      exp_n = r[31];
      exp_v = m_ovf(g, a, b);
      exp_z = (r == 32'd0);
    end
`else
    g = 4'd0;
    r = 32'd0;
`endif
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    status_we = 1'b1;
    pc = 32'd0;
    imm16 = 16'd0;
    set_ops(3'b000, 6'd0, 32'd3, 32'd4);
    #1;
    checks++;
    if ({status_n, status_v, status_z} !== 3'b000)
      $display("FAIL reset_flags: got %b exp 000", {status_n, status_v, status_z});
    else passes++;
    checks++;
    if (result !== 32'd7)
      $display("FAIL reset_comb_result: got %h exp 00000007", result);
    else passes++;
    clock_edge();
    checks++;
    if ({status_n, status_v, status_z} !== 3'b000)
      $display("FAIL reset_edge_flags: got %b exp 000", {status_n, status_v, status_z});
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    status_we = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0] fl;
    // ADD overflow into sign bit
    @(negedge clk);
    set_ops(3'b000, 6'd0, 32'h7FFF_FFFF, 32'h1);
    status_we = 1'b1;
    #1;
    checks++;
    if (result !== 32'h8000_0000 || zero !== 1'b0)
      $display("FAIL add_ovf: got %h z=%b exp 80000000 z=0", result, zero);
    else passes++;
    clock_edge();
`ifdef ALU_STATUS_EN
    fl = 3'b110;
`else
    fl = 3'b000;
`endif
    checks++;
    if ({status_n, status_v, status_z} !== fl || fl !== {exp_n, exp_v, exp_z})
      $display("FAIL add_ovf_flags: got %b exp %b", {status_n, status_v, status_z}, fl);
    else passes++;
    // SUB equal operands
    @(negedge clk);
    set_ops(3'b001, 6'd0, 32'h1234_5678, 32'h1234_5678);
    #1;
    checks++;
    if (result !== 32'd0 || zero !== 1'b1)
      $display("FAIL sub_zero: got %h z=%b exp 00000000 z=1", result, zero);
    else passes++;
    clock_edge();
`ifdef ALU_STATUS_EN
    fl = 3'b001;
`else
    fl = 3'b000;
`endif
    checks++;
    if ({status_n, status_v, status_z} !== fl)
      $display("FAIL sub_zero_flags: got %b exp %b", {status_n, status_v, status_z}, fl);
    else passes++;
    status_we = 1'b0;
    // R-type SLT, including overflowing difference
    @(negedge clk);
    set_ops(3'b010, 6'b101010, 32'hFFFF_FFFF, 32'h1);
    #1;
    checks++;
    if (gout !== 4'b0111 || result !== 32'd1)
      $display("FAIL slt_neg: got g=%b r=%h exp g=0111 r=00000001", gout, result);
    else passes++;
    a = 32'h8000_0000;
    #1;
    checks++;
    if (result !== 32'd1)
      $display("FAIL slt_ovf: got %h exp 00000001", result);
    else passes++;
    a = 32'h7FFF_FFFF;
    b = 32'h8000_0000;
    #1;
    checks++;
    if (result !== 32'd0)
      $display("FAIL slt_ovf_rev: got %h exp 00000000", result);
    else passes++;
    // NOR class and unknown funct
    set_ops(3'b100, 6'd0, 32'h0F0F_0000, 32'h0000_F0F0);
    #1;
    checks++;
    if (gout !== 4'b1100 || result !== 32'hF0F0_0F0F)
      $display("FAIL nor: got g=%b r=%h exp g=1100 r=F0F00F0F", gout, result);
    else passes++;
    set_ops(3'b010, 6'b110000, 32'h5, 32'h6);
    #1;
    checks++;
    if (gout !== 4'b0010 || result !== 32'd11)
      $display("FAIL funct_default: got g=%b r=%h exp g=0010 r=0000000B", gout, result);
    else passes++;
  endtask

  task automatic test_pc();
    logic [31:0] e4, ebt;
    int simm;
    pc = 32'h0000_0010;
    imm16 = 16'hFFFE;
    #1;
    checks++;
    if (pc_plus4 !== 32'h14 || branch_target !== 32'h0C)
      $display("FAIL pc_back: got p4=%h bt=%h exp p4=00000014 bt=0000000C", pc_plus4, branch_target);
    else passes++;
    pc = 32'hFFFF_FFFC;
    imm16 = 16'h0001;
    #1;
    checks++;
    if (pc_plus4 !== 32'h0 || branch_target !== 32'h4)
      $display("FAIL pc_wrap: got p4=%h bt=%h exp p4=00000000 bt=00000004", pc_plus4, branch_target);
    else passes++;
    for (int i = 0; i < 40; i++) begin
      pc = $urandom;
      imm16 = 16'($urandom);
      simm = int'($signed(imm16));
      e4 = pc + 32'd4;
      ebt = pc + 32'd4 + 32'(simm * 4);
      #1;
      checks++;
      if (pc_plus4 !== e4 || branch_target !== ebt)
        $display("FAIL pc_rand: pc=%h imm=%h got p4=%h bt=%h exp p4=%h bt=%h",
                 pc, imm16, pc_plus4, branch_target, e4, ebt);
      else passes++;
    end
  endtask

  task automatic test_flags_reset_hold();
    logic [2:0] fl;
    // set N=1 V=1 Z=0
    @(negedge clk);
    set_ops(3'b000, 6'd0, 32'h7FFF_FFFF, 32'h1);
    status_we = 1'b1;
    clock_edge();
    // hold with status_we low while inputs change
    @(negedge clk);
    status_we = 1'b0;
    set_ops(3'b001, 6'd0, 32'h9, 32'h9);
    clock_edge();
    clock_edge();
`ifdef ALU_STATUS_EN
    fl = 3'b110;
`else
    fl = 3'b000;
`endif
    checks++;
    if ({status_n, status_v, status_z} !== fl)
      $display("FAIL flag_hold: got %b exp %b", {status_n, status_v, status_z}, fl);
    else passes++;
    // asynchronous reset in mid-cycle
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_n = 1'b0; exp_v = 1'b0; exp_z = 1'b0;
    #1;
    checks++;
    if ({status_n, status_v, status_z} !== 3'b000)
      $display("FAIL async_reset: got %b exp 000", {status_n, status_v, status_z});
    else passes++;
    // reset wins over a capture edge
    set_ops(3'b000, 6'd0, 32'h7FFF_FFFF, 32'h1);
    status_we = 1'b1;
    clock_edge();
    checks++;
    if ({status_n, status_v, status_z} !== 3'b000)
      $display("FAIL reset_wins: got %b exp 000", {status_n, status_v, status_z});
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    status_we = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0]  fl [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd0};
    logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};
    logic [3:0]  eg;
    logic [31:0] er;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      aluop = 3'($urandom_range(0, 7));
      funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 7)];
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      status_we = 1'($urandom);
      #1;
      eg = m_gout(aluop, funct);
      er = m_result(eg, a, b);
      checks++;
      if (gout !== eg)
        $display("FAIL rand_gout: op=%b f=%b got %b exp %b", aluop, funct, gout, eg);
      else passes++;
      checks++;
      if (result !== er || zero !== (er == 32'd0))
        $display("FAIL rand_result: g=%b a=%h b=%h got %h z=%b exp %h", eg, a, b, result, zero, er);
      else passes++;
      clock_edge();
      checks++;
      if ({status_n, status_v, status_z} !== {exp_n, exp_v, exp_z})
        $display("FAIL rand_flags: got %b exp %b", {status_n, status_v, status_z}, {exp_n, exp_v, exp_z});
      else passes++;
    end
    status_we = 1'b0;
  endtask

  // flags show the previous capture while the next operation is on the inputs
  task automatic test_back_to_back();
    logic [2:0] prev;
    status_we = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      prev = {exp_n, exp_v, exp_z};
      set_ops(3'($urandom_range(0, 1)), 6'd0,
              (i % 3 == 0) ? 32'h8000_0000 : $urandom, (i % 2 == 0) ? 32'h8000_0000 : $urandom);
      #1;
      checks++;
      if ({status_n, status_v, status_z} !== prev)
        $display("FAIL b2b_old: got %b exp %b", {status_n, status_v, status_z}, prev);
      else passes++;
      clock_edge();
      checks++;
      if ({status_n, status_v, status_z} !== {exp_n, exp_v, exp_z})
        $display("FAIL b2b_new: got %b exp %b", {status_n, status_v, status_z}, {exp_n, exp_v, exp_z});
      else passes++;
    end
    status_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_pc();
    test_flags_reset_hold();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
